// File: rtl/rx_arb_pkg.sv
// rx_arb_pkg -- shared types and width helpers for the RX lane arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE / BURST)
//   idx_w()     : lane index width, clog2(NUM_LANES), never below 1
//   beat_w()    : beat counter width, clog2(BURST_LEN), never below 1
package rx_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    function automatic int idx_w(input int num_lanes);
        return (num_lanes > 1) ? $clog2(num_lanes) : 1;
    endfunction

    function automatic int beat_w(input int burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

    localparam int LANE_IDX_W = idx_w(4);
    localparam int BEAT_W     = beat_w(8);

endpackage

// File: rtl/rx_lane_arbiter_if.sv
// rx_lane_arbiter_if -- lane input streams plus merged AXI-Stream output.
//   s_lane_*   : NUM_LANES word streams, lane i in bits [i*DATA_W +: DATA_W]
//   m00_axis_* : merged output stream
// modport master : the arbiter (consumes lanes, drives m00_axis)
// modport slave  : the surrounding environment
interface rx_lane_arbiter_if #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 32
);
    import rx_arb_pkg::*;

    localparam int IW = idx_w(NUM_LANES);

    logic [NUM_LANES*DATA_W-1:0] s_lane_tdata;
    logic [NUM_LANES-1:0]        s_lane_tvalid;
    logic [NUM_LANES-1:0]        s_lane_tready;
    logic [DATA_W-1:0]           m00_axis_tdata;
    logic                        m00_axis_tvalid;
    logic                        m00_axis_tready;
    logic [DATA_W/8-1:0]         m00_axis_tstrb;
    logic                        m00_axis_tlast;
    logic [IW-1:0]               m00_axis_tdest;

    modport master (
        input  s_lane_tdata, s_lane_tvalid, m00_axis_tready,
        output s_lane_tready, m00_axis_tdata, m00_axis_tvalid,
               m00_axis_tstrb, m00_axis_tlast, m00_axis_tdest
    );

    modport slave (
        output s_lane_tdata, s_lane_tvalid, m00_axis_tready,
        input  s_lane_tready, m00_axis_tdata, m00_axis_tvalid,
               m00_axis_tstrb, m00_axis_tlast, m00_axis_tdest
    );

endinterface

// File: rtl/rr_pick.sv
// rr_pick -- combinational round-robin selector.
//   req_i        : request vector
//   last_grant_i : previously granted index; search starts just after it
//   found_o      : at least one request set
//   index_o      : first requesting index after last_grant_i, wrapping
module rr_pick #(
    parameter int NUM_LANES = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_LANES-1:0] req_i,
    input  logic [IDX_W-1:0]     last_grant_i,
    output logic                 found_o,
    output logic [IDX_W-1:0]     index_o
);

    always_comb begin
        int cand;
        found_o = 1'b0;
        index_o = '0;
        cand    = 0;
        // k = NUM_LANES revisits last_grant itself, so a lone requester
        // that just finished can be granted again.
        for (int k = 1; k <= NUM_LANES; k++) begin
            cand = (int'(last_grant_i) + k) % NUM_LANES;
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                index_o = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/rx_lane_arbiter.sv
// rx_lane_arbiter -- merges NUM_LANES deserializer word streams into one
// AXI-Stream of BURST_LEN-word packets, round-robin between lanes.
//   m00_axis_aclk    : sole clock
//   m00_axis_aresetn : async active-low reset
//   bus              : lane inputs and merged output (rx_lane_arbiter_if)
//   grant_dbg        : currently granted lane
//   pkt_count        : completed output packets, wraps 0xFFFF -> 0
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no lane locked; pick next valid lane after last_grant
// ST_BURST | locked to grant; forward its words until tlast accepted
module rx_lane_arbiter
    import rx_arb_pkg::*;
#(
    parameter int NUM_LANES              = 4,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int BURST_LEN              = 8
) (
    input  logic                         m00_axis_aclk,
    input  logic                         m00_axis_aresetn,
    rx_lane_arbiter_if.master            bus,
    output logic [idx_w(NUM_LANES)-1:0]  grant_dbg,
    output logic [15:0]                  pkt_count
);

    localparam int W  = C_M00_AXIS_TDATA_WIDTH;
    localparam int IW = idx_w(NUM_LANES);
    localparam int BW = beat_w(BURST_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    arb_state_t    state_q;
    logic [IW-1:0] grant_q;
    logic [IW-1:0] last_grant_q;
    logic [BW-1:0] beat_q;
    logic [W-1:0]  tdata_q;
    logic          tvalid_q;
    logic          tlast_q;
    logic [IW-1:0] tdest_q;
    logic [15:0]   pkt_count_q;

    logic [BW-1:0] beat_d;
    logic [15:0]   pkt_count_d;
    logic          can_load;
    logic          lane_hs;
    logic          out_hs;
    logic          is_last_beat;
    logic          rr_found;
    logic [IW-1:0] rr_idx;
    logic [W-1:0]  lane_word;

    rr_pick #(
        .NUM_LANES (NUM_LANES),
        .IDX_W     (IW)
    ) u_rr_pick (
        .req_i        (bus.s_lane_tvalid),
        .last_grant_i (last_grant_q),
        .found_o      (rr_found),
        .index_o      (rr_idx)
    );

    // Output register accepts a new word when empty or draining this cycle.
    assign can_load     = !tvalid_q || bus.m00_axis_tready;
    assign lane_hs      = (state_q == ST_BURST) && can_load && bus.s_lane_tvalid[grant_q];
    assign out_hs       = tvalid_q && bus.m00_axis_tready;
    assign is_last_beat = (beat_q == LAST_BEAT);
    assign lane_word    = bus.s_lane_tdata[int'(grant_q)*W +: W];
    assign beat_d       = beat_q + 1'b1;
    assign pkt_count_d  = pkt_count_q + 16'd1;

    always_comb begin
        bus.s_lane_tready = '0;
        if (state_q == ST_BURST && can_load) begin
            bus.s_lane_tready[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IW'(NUM_LANES - 1);
            beat_q       <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tdest_q      <= '0;
            pkt_count_q  <= '0;
        end else begin
            if (out_hs && tlast_q) begin
                pkt_count_q <= pkt_count_d;
            end

            if (lane_hs) begin
                tdata_q  <= lane_word;
                tdest_q  <= grant_q;
                tlast_q  <= is_last_beat;
                tvalid_q <= 1'b1;
            end else if (out_hs) begin
                tvalid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (rr_found) begin
                        grant_q <= rr_idx;
                        state_q <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    // A stalled granted lane keeps the lock indefinitely.
                    if (lane_hs) begin
                        if (is_last_beat) begin
                            beat_q       <= '0;
                            last_grant_q <= grant_q;
                            state_q      <= ST_IDLE;
                        end else begin
                            beat_q <= beat_d;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.m00_axis_tdata  = tdata_q;
    assign bus.m00_axis_tvalid = tvalid_q;
    assign bus.m00_axis_tlast  = tlast_q;
    assign bus.m00_axis_tdest  = tdest_q;
    assign bus.m00_axis_tstrb  = '1;
    assign grant_dbg           = grant_q;
    assign pkt_count           = pkt_count_q;

endmodule

// File: tb/tb_rx_lane_arbiter.sv
module tb_rx_lane_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int BL = 8;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rx_lane_arbiter_if #(.NUM_LANES(N), .DATA_W(W)) bus ();
    logic [IW-1:0] grant_dbg;
    logic [15:0]   pkt_count;

    rx_lane_arbiter #(
        .NUM_LANES              (N),
        .C_M00_AXIS_TDATA_WIDTH (W),
        .BURST_LEN              (BL)
    ) dut (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (rst_n),
        .bus              (bus),
        .grant_dbg        (grant_dbg),
        .pkt_count        (pkt_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per-lane word sequence numbers sent and received,
    // packet framing of the merged stream, expected packet count.
    logic [N-1:0] lane_v = '0;
    logic [N-1:0] acc = '0;
    logic [N-1:0] lt_last = '0;
    int sent[N];
    int rcv[N];
    int in_burst[N];
    int beat_pos = 0;
    int pkt_lane = 0;
    int idle_run = 0;
    int cyc = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    logic [15:0] exp_pkt = '0;
    int pkt_order[$];
    int gaps[$];
    bit stall_prev = 1'b0;
    logic [W-1:0]  prev_data;
    logic          prev_last;
    logic [IW-1:0] prev_dest;

    function automatic logic [W-1:0] word(input int lane, input int n);
        return {8'(lane), 16'(n), 8'(8'hA0 + n)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.s_lane_tvalid = lane_v;
        for (int i = 0; i < N; i++) bus.s_lane_tdata[i*W +: W] = word(i, sent[i]);
    endtask

    task automatic score();
        if (beat_pos == 0) begin
            pkt_lane = int'(bus.m00_axis_tdest);
            pkt_order.push_back(pkt_lane);
            gaps.push_back(idle_run);
            first_cyc = cyc;
        end
        chk("tdest", bus.m00_axis_tdest, pkt_lane);
        chk("tdata", bus.m00_axis_tdata, word(pkt_lane, rcv[pkt_lane]));
        chk("tlast", bus.m00_axis_tlast, (beat_pos == BL-1));
        rcv[pkt_lane]++;
        if (beat_pos == BL-1) begin
            beat_pos = 0;
            exp_pkt++;
            last_cyc = cyc;
        end else begin
            beat_pos++;
        end
    endtask

    // One clock: entered and left just after a falling edge.
    task automatic step();
        logic [N-1:0] lt;
        drive();
        #1;
        lt = bus.s_lane_tready;
        lt_last = lt;
        chk("lane_tready_onehot", ($countones(lt) <= 1), 1);
        if (bus.m00_axis_tvalid && !bus.m00_axis_tready) chk("lane_tready_when_full", lt, 0);
        if (stall_prev) begin
            chk("hold_tvalid", bus.m00_axis_tvalid, 1);
            chk("hold_tdata", bus.m00_axis_tdata, prev_data);
            chk("hold_tlast", bus.m00_axis_tlast, prev_last);
            chk("hold_tdest", bus.m00_axis_tdest, prev_dest);
        end
        stall_prev = bus.m00_axis_tvalid && !bus.m00_axis_tready;
        prev_data  = bus.m00_axis_tdata;
        prev_last  = bus.m00_axis_tlast;
        prev_dest  = bus.m00_axis_tdest;
        if (bus.m00_axis_tvalid && bus.m00_axis_tready) score();
        if (bus.m00_axis_tvalid) idle_run = 0;
        else idle_run++;
        for (int i = 0; i < N; i++) begin
            acc[i] = lt[i] && lane_v[i];
            if (acc[i]) begin
                sent[i]++;
                in_burst[i] = (in_burst[i] + 1) % BL;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("pkt_count", pkt_count, exp_pkt);
        drive();
    endtask

    task automatic check_reset_vals();
        chk("rst_tvalid", bus.m00_axis_tvalid, 0);
        chk("rst_tlast", bus.m00_axis_tlast, 0);
        chk("rst_tdata", bus.m00_axis_tdata, 0);
        chk("rst_tdest", bus.m00_axis_tdest, 0);
        chk("rst_grant", grant_dbg, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_lane_tready", bus.s_lane_tready, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        for (int i = 0; i < N; i++) begin
            rcv[i] = sent[i];
            in_burst[i] = 0;
        end
        acc = '0;
        lane_v = '0;
        beat_pos = 0;
        exp_pkt = '0;
        stall_prev = 1'b0;
        idle_run = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive();
    endtask

    // Lets partial bursts finish and held-valid lanes be served, then idles.
    task automatic drain();
        bit done;
        done = 1'b0;
        bus.m00_axis_tready = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) lane_v[i] = (lane_v[i] && !acc[i]) || (in_burst[i] != 0);
            done = (lane_v == '0) && !bus.m00_axis_tvalid;
            for (int i = 0; i < N; i++) if (rcv[i] != sent[i]) done = 1'b0;
            if (done) break;
            step();
        end
        chk("drain_done", done, 1);
    endtask

    initial begin
        int k;
        int s0;
        int s1;
        logic [15:0] p0;
        for (int i = 0; i < N; i++) begin
            sent[i] = 0;
            rcv[i] = 0;
            in_burst[i] = 0;
        end

        // Reset values, with every lane requesting.
        lane_v = '1;
        bus.m00_axis_tready = 1'b1;
        drive();
        @(negedge clk);
        @(negedge clk);
        check_reset_vals();
        chk("tstrb_ones", bus.m00_axis_tstrb, 4'hF);
        lane_v = '0;
        drive();
        rst_n = 1'b1;
        @(negedge clk);

        // Single lane 2 packet, latency and contiguity.
        lane_v = 4'b0100;
        k = 0;
        while (!bus.m00_axis_tvalid && k < 10) begin
            step();
            k++;
        end
        chk("first_out_latency", k, 2);
        for (int j = 0; j < 40 && exp_pkt != 16'd1; j++) begin
            if (sent[2] >= BL) lane_v[2] = 1'b0;
            step();
        end
        chk("single_pkt_count", pkt_count, 1);
        chk("single_beats_contig", last_cyc - first_cyc, BL-1);
        chk("single_lane", pkt_order[0], 2);
        drain();

        // Fairness with lanes 0,1,3 always valid.
        do_reset();
        pkt_order.delete();
        gaps.delete();
        lane_v = 4'b1011;
        for (int j = 0; j < 200 && pkt_order.size() < 7; j++) step();
        chk("fair_pkts_seen", pkt_order.size() >= 7, 1);
        if (pkt_order.size() >= 7) begin
            chk("fair_order0", pkt_order[0], 0);
            chk("fair_order1", pkt_order[1], 1);
            chk("fair_order2", pkt_order[2], 3);
            chk("fair_order3", pkt_order[3], 0);
            chk("fair_order4", pkt_order[4], 1);
            chk("fair_order5", pkt_order[5], 3);
            for (int j = 1; j < 6; j++) chk("fair_bubble", gaps[j], 1);
        end
        drain();

        // Backpressure: downstream ready toggles during a burst.
        s0 = sent[0];
        p0 = exp_pkt;
        lane_v = 4'b0001;
        for (int j = 0; j < 100 && exp_pkt == p0; j++) begin
            bus.m00_axis_tready = (j % 2 == 0);
            if (sent[0] - s0 >= BL) lane_v[0] = 1'b0;
            step();
        end
        chk("bp_pkt_done", pkt_count, p0 + 16'd1);
        chk("bp_words", rcv[0] - s0, BL);
        drain();

        // Granted lane 1 stalls after four beats while lane 0 waits.
        pkt_order.delete();
        s1 = sent[1];
        lane_v = 4'b0010;
        bus.m00_axis_tready = 1'b1;
        for (int j = 0; j < 30 && sent[1] - s1 < 4; j++) begin
            if (sent[1] - s1 >= 1) lane_v[0] = 1'b1;
            step();
        end
        chk("stall_four_beats", sent[1] - s1, 4);
        lane_v[0] = 1'b1;
        lane_v[1] = 1'b0;
        for (int j = 0; j < 20; j++) begin
            step();
            chk("stall_lane0_tready", lt_last[0], 0);
            chk("stall_grant", grant_dbg, 1);
        end
        lane_v[1] = 1'b1;
        drain();
        chk("stall_pkts", pkt_order.size(), 2);
        if (pkt_order.size() == 2) begin
            chk("stall_first_lane", pkt_order[0], 1);
            chk("stall_second_lane", pkt_order[1], 0);
        end

        // Reset in the middle of a lane 2 burst.
        pkt_order.delete();
        lane_v = 4'b0100;
        for (int j = 0; j < 40 && !(beat_pos == 5 && bus.m00_axis_tvalid); j++) step();
        chk("rst_mid_reached", (beat_pos == 5) && bus.m00_axis_tvalid, 1);
        do_reset();
        pkt_order.delete();
        lane_v = 4'b1111;
        for (int j = 0; j < 20 && pkt_order.size() < 1; j++) step();
        chk("post_rst_first_lane", (pkt_order.size() > 0) ? pkt_order[0] : -1, 0);
        drain();

        // Packet counter wrap.
        force dut.pkt_count_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.pkt_count_q;
        exp_pkt = 16'hFFFF;
        step();
        chk("wrap_preload", pkt_count, 16'hFFFF);
        lane_v = 4'b1000;
        drain();
        chk("wrap_to_zero", pkt_count, 0);

        // Randomized traffic and backpressure; lanes hold valid until accepted.
        for (int j = 0; j < 2000; j++) begin
            for (int i = 0; i < N; i++)
                if (!(lane_v[i] && !acc[i])) lane_v[i] = ($urandom_range(0, 2) == 0);
            bus.m00_axis_tready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();
        for (int i = 0; i < N; i++) chk("rand_lane_total", rcv[i], sent[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
